// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter that runs one bus transaction at a time: grant, select strobe, then wait for ok or time out.
// Latency: grant and o_sel appear one edge after a request is seen in IDLE; at most 3 + TIMEOUT cycles per transaction.
// Backpressure: requests are sampled only in IDLE; other requesters hold i_req until they are granted.
module rr_bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_wr,
    input  logic             i_ok,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_sel,
    output logic             o_write,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_err,
    output logic [2:0]       o_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;

    logic [2:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             sel_q, sel_d;
    logic             write_q, write_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    win_q, win_d;

    logic             scan_found;
    logic [IW-1:0]    scan_win;
    logic [IW:0]      scan_sum;
    logic [IW-1:0]    scan_idx;
    logic             wait_expired;

    assign wait_expired = (cnt_q == TO_W'(TIMEOUT - 1));

    // Scan starts just after the last winner and wraps, so nobody is served twice while others wait.
    always_comb begin
        scan_found = 1'b0;
        scan_win   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_sum = {1'b0, last_q} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (IW+1)'(N_REQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!scan_found && i_req[scan_idx]) begin
                scan_found = 1'b1;
                scan_win   = scan_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = scan_found ? S_ADDR : S_IDLE;
            S_ADDR:  state_d = S_WAIT;
            S_WAIT:  state_d = (i_ok || wait_expired) ? S_DONE : S_WAIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and the datapath state.
    always_comb begin
        gnt_d   = gnt_q;
        sel_d   = 1'b0;
        write_d = write_q;
        done_d  = '0;
        err_d   = '0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                gnt_d   = '0;
                write_d = 1'b0;
                if (scan_found) begin
                    gnt_d[scan_win] = 1'b1;
                    write_d         = i_wr[scan_win];
                    sel_d           = 1'b1;
                    win_d           = scan_win;
                end
            end
            S_ADDR: cnt_d = '0;
            S_WAIT: begin
                // ok on the final timeout cycle still counts as success.
                if (i_ok) begin
                    done_d[win_q] = 1'b1;
                end else if (wait_expired) begin
                    err_d[win_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                write_d = 1'b0;
                last_d  = win_q;
            end
            default: begin
                gnt_d   = '0;
                write_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_q   <= '0;
            sel_q   <= 1'b0;
            write_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            win_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            write_q <= write_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_sel   = sel_q;
    assign o_write = write_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (N_REQ=4, TIMEOUT=15): ordering, timeout, reset abort and latching.
module tb_rr_bus_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_req;
    logic [3:0] i_wr;
    logic       i_ok;
    logic [3:0] o_gnt;
    logic       o_sel;
    logic       o_write;
    logic [3:0] o_done;
    logic [3:0] o_err;
    logic [2:0] o_state;

    int n_assert = 0;
    int n_fail   = 0;

    rr_bus_arbiter #(.N_REQ(4), .TIMEOUT(15), .TO_W(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_wr    (i_wr),
        .i_ok    (i_ok),
        .o_gnt   (o_gnt),
        .o_sel   (o_sel),
        .o_write (o_write),
        .o_done  (o_done),
        .o_err   (o_err),
        .o_state (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"},   32'(o_gnt),   32'h0);
        check({tag, " sel"},   32'(o_sel),   32'h0);
        check({tag, " write"}, 32'(o_write), 32'h0);
        check({tag, " done"},  32'(o_done),  32'h0);
        check({tag, " err"},   32'(o_err),   32'h0);
        check({tag, " state"}, 32'(o_state), 32'h0);
    endtask

    initial begin
        int waits;
        logic [3:0] exp_gnt;

        i_rst_n = 1'b0;
        i_req   = 4'b0000;
        i_wr    = 4'b0000;
        i_ok    = 1'b0;
        #12;
        check_all_zero("reset");
        i_rst_n = 1'b1;

        // ok while idle with no request is ignored
        i_ok = 1'b1;
        step();
        check("idle ok ignored", 32'(o_state), 32'd0);
        i_ok = 1'b0;

        // 1: single write transaction, ok on third WAIT cycle
        i_req = 4'b0100;
        i_wr  = 4'b0100;
        step();
        check("t1 state addr", 32'(o_state), 32'd1);
        check("t1 gnt",        32'(o_gnt),   32'h4);
        check("t1 sel",        32'(o_sel),   32'h1);
        check("t1 write",      32'(o_write), 32'h1);
        i_req = 4'b0000;
        step();
        check("t1 state wait1", 32'(o_state), 32'd2);
        check("t1 sel low",     32'(o_sel),   32'h0);
        step();
        check("t1 state wait2", 32'(o_state), 32'd2);
        step();
        check("t1 state wait3", 32'(o_state), 32'd2);
        i_ok = 1'b1;
        step();
        check("t1 state done", 32'(o_state), 32'd3);
        check("t1 done",       32'(o_done),  32'h4);
        check("t1 err",        32'(o_err),   32'h0);
        check("t1 gnt held",   32'(o_gnt),   32'h4);
        i_ok = 1'b0;
        step();
        check_all_zero("t1 idle");

        // 2: all request, immediate ok; reset first so the pointer starts at N_REQ-1
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
        i_req = 4'b1111;
        i_wr  = 4'b0000;
        i_ok  = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp_gnt = 4'b0001 << (t % 4);
            step();
            check($sformatf("t2 gnt%0d", t), 32'(o_gnt), 32'(exp_gnt));
            check($sformatf("t2 sel%0d", t), 32'(o_sel), 32'h1);
            step();
            step();
            check($sformatf("t2 done%0d", t), 32'(o_done), 32'(exp_gnt));
            if (t == 4) begin
                i_req = 4'b0000;
                i_ok  = 1'b0;
            end
            step();
            check($sformatf("t2 idle%0d", t), 32'(o_gnt), 32'h0);
        end

        // 3: no ok -> timeout after exactly 15 WAIT cycles
        i_req = 4'b0010;
        step();
        check("t3 gnt", 32'(o_gnt), 32'h2);
        i_req = 4'b0000;
        step();
        waits = 0;
        while (o_state == 3'd2 && waits < 40) begin
            waits++;
            if (o_err != 4'b0000 || o_done != 4'b0000) begin
                check("t3 early pulse", 32'({o_err, o_done}), 32'h0);
            end
            step();
        end
        check("t3 wait cycles", 32'(waits),   32'd15);
        check("t3 state done",  32'(o_state), 32'd3);
        check("t3 err",         32'(o_err),   32'h2);
        check("t3 done",        32'(o_done),  32'h0);
        step();
        check_all_zero("t3 idle");

        // 4: ok on exactly the 15th WAIT cycle -> done, not err
        i_req = 4'b0010;
        step();
        check("t4 gnt", 32'(o_gnt), 32'h2);
        i_req = 4'b0000;
        step();
        for (int i = 0; i < 14; i++) step();
        check("t4 still wait", 32'(o_state), 32'd2);
        i_ok = 1'b1;
        step();
        check("t4 done", 32'(o_done),  32'h2);
        check("t4 err",  32'(o_err),   32'h0);
        i_ok = 1'b0;
        step();

        // 5: reset during WAIT of requester 1
        i_req = 4'b0010;
        step();
        check("t5 gnt", 32'(o_gnt), 32'h2);
        i_req = 4'b0000;
        step();
        step();
        i_rst_n = 1'b0;
        #1;
        check_all_zero("t5 async reset");
        step();
        step();
        check("t5 no done", 32'(o_done), 32'h0);
        check("t5 no err",  32'(o_err),  32'h0);
        i_rst_n = 1'b1;
        i_req = 4'b0011;
        step();
        check("t5 ptr reset gnt", 32'(o_gnt), 32'h1);
        i_req = 4'b0000;
        i_ok  = 1'b1;
        step();
        step();
        check("t5 done", 32'(o_done), 32'h1);
        i_ok = 1'b0;
        step();

        // 6: winner drops request and toggles i_wr mid-transaction
        i_req = 4'b0001;
        i_wr  = 4'b0001;
        step();
        check("t6 gnt",   32'(o_gnt),   32'h1);
        check("t6 write", 32'(o_write), 32'h1);
        i_req = 4'b0000;
        i_wr  = 4'b0000;
        step();
        check("t6 gnt held w", 32'(o_gnt),   32'h1);
        check("t6 write held", 32'(o_write), 32'h1);
        i_wr = 4'b1111;
        step();
        i_wr = 4'b0000;
        i_ok = 1'b1;
        step();
        check("t6 state done", 32'(o_state), 32'd3);
        check("t6 gnt done",   32'(o_gnt),   32'h1);
        check("t6 write done", 32'(o_write), 32'h1);
        check("t6 done",       32'(o_done),  32'h1);
        i_ok = 1'b0;
        step();
        check_all_zero("t6 idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Shares one bus transaction engine among N_REQ requesters using round-robin arbitration.
- Sequences one transaction at a time: grant, a one-cycle select strobe with direction, then wait for the slave's ok, with a timeout.
- Sits upstream of the bus control state machine. Its o_sel/o_write feed that FSM's select/write inputs; i_ok is shared with it.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 15, max WAIT cycles without i_ok before abort (1..2^TO_W-1).
- TO_W, 4, timeout counter width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous reset, active-low.
- i_req  input  N_REQ  per-requester request level.
- i_wr  input  N_REQ  per-requester direction: 1 = write, 0 = read.
- i_ok  input  1  slave transfer complete.
- o_gnt  output  N_REQ  one-hot grant, held for the whole transaction.
- o_sel  output  1  bus select strobe.
- o_write  output  1  direction of the granted transaction.
- o_done  output  N_REQ  one-cycle pulse: transfer completed with ok.
- o_err  output  N_REQ  one-cycle pulse: transfer aborted by timeout.
- o_state  output  3  current state encoding, for debug.

Behaviour:
- Clock and reset: i_clk is the clock. i_rst_n is an asynchronous, active-low reset.
- Reset values:
  - state = IDLE (3'd0).
  - o_gnt, o_sel, o_write, o_done, o_err = 0.
  - Timeout counter = 0.
  - Last-winner pointer = N_REQ-1, so requester 0 has top priority first.
- All outputs are registered.
- States:
  - IDLE = 0, ADDR = 1, WAIT = 2, DONE = 3.
  - Codes 4-7 are illegal and go to IDLE on the next edge with all outputs cleared.
- IDLE:
  - If i_req != 0, pick the winner by scanning from (last+1) mod N_REQ upward with wrap.
  - On the edge: o_gnt = onehot(winner), o_write = i_wr[winner], o_sel = 1, state -> ADDR.
  - Otherwise stay in IDLE.
  - Requests are sampled only in IDLE.
- ADDR:
  - o_sel is high for exactly this one cycle.
  - Next edge: o_sel = 0, counter = 0, state -> WAIT.
  - o_gnt and o_write are held.
- WAIT:
  - Each cycle with i_ok = 1: next edge sets o_done[winner] = 1, state -> DONE.
  - Otherwise, if counter == TIMEOUT-1: next edge sets o_err[winner] = 1, state -> DONE.
  - Otherwise the counter increments.
  - WAIT therefore lasts at most TIMEOUT cycles.
  - i_ok and the final timeout cycle together: ok wins, so o_done fires, not o_err.
- DONE:
  - The o_done/o_err pulse is high for this one cycle.
  - o_gnt is still held during DONE.
  - Next edge: o_gnt = 0, o_done = 0, o_err = 0, o_write = 0, last = winner, state -> IDLE.
  - The bus is idle for at least one cycle between transactions, so back-to-back grants are 4 cycles apart minimum with immediate ok.
- Latency: request high before edge k gives o_sel high and o_gnt valid after edge k.
- Boundary conditions:
  - The winner deasserting i_req mid-transaction does not abort; the transaction completes.
  - Other requests arriving mid-transaction wait for IDLE.
  - i_wr changes after grant are ignored, because o_write is latched.
  - i_ok in IDLE, ADDR or DONE is ignored.
  - Reset mid-transaction clears everything immediately and asynchronously; no o_done or o_err is issued for the lost transfer.
  - Pointer wrap: when last = N_REQ-1, the scan starts at 0.

Test Plan:
1. Reset, then i_req=4'b0100, i_wr[2]=1, i_ok pulsed on the 3rd WAIT cycle -> o_gnt=4'b0100 and o_sel=1 for one cycle with o_write=1; o_done=4'b0100 for one cycle; back to IDLE; o_state sequence 0,1,2,2,2,3,0.
2. i_req=4'b1111 held, i_ok=1 always -> grants in order 0,1,2,3,0 with one-hot o_gnt, each transaction 4 cycles, no requester granted twice before all others are served.
3. i_req=4'b0010, i_ok never asserted, TIMEOUT=15 -> WAIT lasts exactly 15 cycles, o_err=4'b0010 for one cycle, o_done stays 0, arbiter returns to IDLE.
4. i_ok asserted on exactly the 15th WAIT cycle -> o_done pulses, o_err stays 0.
5. i_rst_n driven low during WAIT of requester 1 -> all outputs 0 immediately, no done/err pulse; after release, requester 0 wins over 1 when both request (pointer reset to N_REQ-1).
6. Winner drops i_req during WAIT and i_wr toggles -> grant and o_write held until DONE; o_done still pulses on i_ok.
